// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and byte-lane helper for the data-memory port arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_t;

  localparam int unsigned LANE_MAX_W = 64;

  // Lane 0 is the most significant byte of an nbytes-wide word.
  function automatic logic [7:0] be_lane(input logic [LANE_MAX_W-1:0] word,
                                         input int unsigned nbytes,
                                         input int unsigned idx);
    logic [LANE_MAX_W-1:0] w_sh;
    w_sh = word >> (8 * (nbytes - 1 - idx));
    return w_sh[7:0];
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// rtl/dmem_port_arbiter_rr_arb2.sv - two-requester round-robin picker
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  owner_t     i_rr,
  output owner_t     o_grant,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    if (i_req == 2'b11) begin
      o_grant = i_rr;
    end else if (i_req[1]) begin
      o_grant = OWN_DBG;
    end else begin
      o_grant = OWN_CORE;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - serializes word accesses from core and debug ports onto a byte-wide memory
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NBYTES  = 4,
  parameter bit          RR_INIT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_W-1:0]     core_addr,
  input  logic [8*NBYTES-1:0]   core_wdata,
  output logic [8*NBYTES-1:0]   core_rdata,
  output logic                  core_done,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_W-1:0]     dbg_addr,
  input  logic [8*NBYTES-1:0]   dbg_wdata,
  output logic [8*NBYTES-1:0]   dbg_rdata,
  output logic                  dbg_done,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  busy
);

  localparam int unsigned WORD_W = 8 * NBYTES;
  localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  owner_t              r_rr;
  owner_t              r_owner;
  owner_t              w_grant;
  logic                w_grant_vld;
  logic                r_we_q;
  logic [ADDR_W-1:0]   r_addr_q;
  logic [WORD_W-1:0]   r_wdata_q;
  logic [WORD_W-1:0]   r_rshift;
  logic [WORD_W-1:0]   r_core_rdata;
  logic [WORD_W-1:0]   r_dbg_rdata;
  logic [WORD_W-1:0]   w_rword;
  logic                w_last;

  rr_arb2 u_rr_arb2 (
    .i_req   ({dbg_req, core_req}),
    .i_rr    (r_rr),
    .o_grant (w_grant),
    .o_valid (w_grant_vld)
  );

  assign w_last = (r_cnt == CNT_LAST);
  // Bytes arrive MSB first, so shifting left and appending lands each one in its big-endian lane.
  assign w_rword = WORD_W'({r_rshift, mem_rdata});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_grant_vld) w_state_nxt = XFER;
      XFER:    if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    core_done = 1'b0;
    dbg_done  = 1'b0;
    case (r_state)
      XFER: begin
        busy      = 1'b1;
        mem_we    = r_we_q;
        mem_addr  = r_addr_q + ADDR_W'(r_cnt);
        mem_wdata = be_lane(LANE_MAX_W'(r_wdata_q), NBYTES, 32'(r_cnt));
      end
      DONE: begin
        busy      = 1'b1;
        core_done = (r_owner == OWN_CORE);
        dbg_done  = (r_owner == OWN_DBG);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_rr         <= owner_t'(RR_INIT);
      r_owner      <= OWN_CORE;
      r_we_q       <= 1'b0;
      r_addr_q     <= '0;
      r_wdata_q    <= '0;
      r_rshift     <= '0;
      r_core_rdata <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_vld) begin
            r_owner <= w_grant;
            r_cnt   <= '0;
            if (w_grant == OWN_DBG) begin
              r_we_q    <= dbg_we;
              r_addr_q  <= dbg_addr;
              r_wdata_q <= dbg_wdata;
            end else begin
              r_we_q    <= core_we;
              r_addr_q  <= core_addr;
              r_wdata_q <= core_wdata;
            end
          end
        end
        XFER: begin
          r_cnt <= r_cnt + 1'b1;
          if (!r_we_q) begin
            r_rshift <= w_rword;
            // Publish on the last byte edge so the word is already visible during DONE.
            if (w_last) begin
              if (r_owner == OWN_DBG) begin
                r_dbg_rdata <= w_rword;
              end else begin
                r_core_rdata <= w_rword;
              end
            end
          end
        end
        DONE: begin
          r_rr <= (r_owner == OWN_CORE) ? OWN_DBG : OWN_CORE;
        end
        default: ;
      endcase
    end
  end

  assign core_rdata = r_core_rdata;
  assign dbg_rdata  = r_dbg_rdata;

endmodule
